// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmit buffer: byte stores to TX_ADDR are queued in a
// circular FIFO and drained one at a time into the serial transmitter.

package uart_tx_fifo_pkg;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } mem_write_width_t;

  typedef struct packed {
    logic [31:0]      addr;
    mem_write_width_t width;
    logic [31:0]      value;
    logic             enable;
  } mem_write_control_t;
endpackage

module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] TX_ADDR = 32'h0003_0000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  mem_write_control_t       memory_mapped_io_control,
  output logic                     memory_mapped_io_write_complete,
  output logic [7:0]               tx_data,
  output logic                     tx_data_available,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_PRESENT} drain_state_e;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accepted_q, accepted_d;
  drain_state_e     state_q, state_d;

  logic req_match;
  logic is_byte;
  logic push;
  logic pop;
  logic unused_value_bits;

  assign unused_value_bits = ^memory_mapped_io_control.value[31:8];

  assign req_match  = memory_mapped_io_control.enable &&
                      (memory_mapped_io_control.addr == TX_ADDR);
  assign is_byte    = (memory_mapped_io_control.width == write_byte);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;

  // accepted_q blocks a second push while the hart keeps the same store asserted.
  assign push = req_match && is_byte && !fifo_full && !accepted_q;
  assign pop  = (state_q == ST_PRESENT) && !tx_ready;

  // Wider stores to the data register complete at once and are discarded.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    memory_mapped_io_write_complete = 1'b0;
    if (req_match) begin
      memory_mapped_io_write_complete = is_byte ? accepted_q : 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;

    if (!memory_mapped_io_control.enable) begin
      accepted_d = 1'b0;
    end else if (push) begin
      accepted_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM; returning to IDLE waits for tx_ready so one byte is never offered twice.
  always_comb begin
    state_d           = state_q;
    tx_data_available = 1'b0;
    tx_data           = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && tx_ready) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        tx_data_available = 1'b1;
        tx_data           = mem_q[rd_ptr_q];
        if (!tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      accepted_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      state_q    <= state_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= memory_mapped_io_control.value[7:0];
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Memory-mapped UART transmit buffer between the hart's memory-mapped I/O write port and `serial_transmitter`. It accepts byte stores to the TX data address into a circular FIFO and completes them as soon as they are buffered, so the core stalls only when the FIFO is full. A drain state machine feeds queued bytes to the serial transmitter one at a time using the transmitter's ready/available handshake.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `TX_ADDR`, 32'h00030000: MMIO address of the TX data register.

Ports:
- `clock`  input  1  system clock; all state on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `memory_mapped_io_control`  input  `mem_write_control_t`  hart store request (`addr`, `width`, `value`, `enable`).
- `memory_mapped_io_write_complete`  output  1  store-accepted indication to the hart.
- `tx_data`  output  8  byte offered to `serial_transmitter`.
- `tx_data_available`  output  1  `tx_data` valid.
- `tx_ready`  input  1  transmitter idle; it falls when the transmitter latches a byte.
- `fifo_count`  output  $clog2(DEPTH)+1  current occupancy.
- `fifo_full`  output  1  `fifo_count == DEPTH`.
- `fifo_empty`  output  1  `fifo_count == 0`.

## Operation
- Storage: `DEPTH`×8 array, read and write pointers of $clog2(DEPTH) bits that wrap modulo `DEPTH`, and a separate occupancy counter.
- Request match: `enable && addr == TX_ADDR`.
- Byte push: on a matched request with `width == write_byte`, `fifo_full == 0`, and `accepted == 0`, write `value[7:0]` at the write pointer, advance it, and set `accepted`.
- `accepted` clears on any cycle with `enable == 0`. It blocks a duplicate push while the hart holds the same request. The hart must drop `enable` between consecutive stores.
- Write completion:
  - For a matched byte store, `memory_mapped_io_write_complete = accepted`, driven combinationally from the register.
  - For a matched store of halfword or word width, the output is 1 combinationally. Nothing is pushed, and the data is discarded.
  - Unmatched addresses: 0; the block ignores them.
- Full FIFO: the push is withheld and the completion stays 0, so the hart stalls. The push happens on the first edge after a pop frees an entry.
- Drain FSM:
  - IDLE (`tx_data_available = 0`): go to PRESENT when `fifo_empty == 0 && tx_ready == 1`.
  - PRESENT (`tx_data_available = 1`): `tx_data` holds the head entry, stable for the whole state. When `tx_ready == 0` is sampled, pop (advance the read pointer) and return to IDLE.
  - IDLE requires `tx_ready == 1` before presenting again. This prevents one byte from being accepted twice.
- Push and pop in the same cycle: the counter is unchanged and both pointers advance. A push into an empty FIFO is not visible to the drain FSM until the following cycle (no bypass).

## Timing
- Reset (`reset_n == 0`, asynchronous):
  - Pointers and counter go to 0; `accepted` goes to 0; FSM goes to IDLE.
  - Outputs: `tx_data_available = 0`, `fifo_empty = 1`, `fifo_full = 0`, `fifo_count = 0`, `memory_mapped_io_write_complete = 0`.
  - `tx_data` is don't-care while IDLE. It is driven as 0 in reset.
  - Array contents are not reset.
- Reset mid-operation: queued bytes are lost. If the transmitter has already latched a byte, that byte still goes out. Deassertion of `reset_n` is synchronous to `clock` at system level.
- Store latency: request at edge N with space free → push at N → `write_complete` high in cycle N+1 until `enable` falls.
- Drain latency: a byte pushed at edge N, with IDLE and `tx_ready == 1`, gives PRESENT with `tx_data_available = 1` in cycle N+2. Pop occurs at the first edge where `tx_ready == 0`.
- Throughput: one byte per transmitter frame. The FSM adds 1 cycle after `tx_ready` returns high.

## Test plan
- Reset with `enable` held high → all outputs at reset values; no push occurs until `reset_n` rises.
- Single store of 8'h41 to 0x00030000 as a byte, with `tx_ready` high → `write_complete` high 1 cycle after the push; `tx_data_available` high with `tx_data` = 8'h41; bench drops `tx_ready` → pop occurs, `fifo_count` returns to 0, and `tx_data_available` falls.
- `tx_ready` held low, 16 stores of 8'h00–8'h0F → all complete and `fifo_full` = 1. The 17th store stalls (no completion) until `tx_ready` pulses. Output order is 00..0F, then 8'h10, with pointer wrap verified.
- `enable` held for 10 cycles on one byte store → exactly one push (`fifo_count` = 1).
- Word-width store to `TX_ADDR` → immediate completion and `fifo_count` unchanged. Byte store to 0x00030004 → no completion and no push.
- Push on the same edge as a pop at `fifo_count` = 3 → `fifo_count` stays 3. `reset_n` asserted during PRESENT → `tx_data_available` falls without waiting for a clock edge.
